// File: rtl/decode_scoreboard_pkg.sv
// Shared types and encodings for the decode-stage hazard scoreboard.
package decode_scoreboard_pkg;

  localparam int unsigned REG_W = 3;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] regsel;
    logic             is_load;
  } entry_t;

endpackage

// File: rtl/scoreboard_match.sv
// Compares one ID source operand against the EX and MEM in-flight destinations.
module scoreboard_match
  import decode_scoreboard_pkg::*;
(
  input  logic             en,
  input  logic [REG_W-1:0] regsel,
  input  entry_t           ex,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_regsel,
  output logic             hit_ex,
  output logic             hit_ex_load,
  output logic             hit_mem
);

  always_comb begin
    hit_ex      = en & ex.valid & (ex.regsel == regsel);
    hit_ex_load = hit_ex & ex.is_load;
    hit_mem     = en & mem_valid & (mem_regsel == regsel);
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard unit: ID stall, registered EX forwarding selects, stall counter.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned FORWARD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_read1en,
  input  logic             id_read2en,
  input  logic [REG_W-1:0] id_read1regsel,
  input  logic [REG_W-1:0] id_read2regsel,
  input  logic             id_write,
  input  logic [REG_W-1:0] id_writeregsel,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [FWD_W-1:0] ex_fwd1,
  output logic [FWD_W-1:0] ex_fwd2,
  output logic [CNT_W-1:0] stall_count,
  output logic             err
);

  // WB needs no storage: the bypassing register file already covers WB-to-ID.
  entry_t           ex_q;
  logic             mem_valid_q;
  logic [REG_W-1:0] mem_regsel_q;

  logic             hit1_ex, hit1_ex_load, hit1_mem;
  logic             hit2_ex, hit2_ex_load, hit2_mem;
  logic             stall_cond;
  logic [FWD_W-1:0] fwd1_d, fwd2_d;
  entry_t           ex_d;

  scoreboard_match u_match1 (
    .en          (id_valid & id_read1en),
    .regsel      (id_read1regsel),
    .ex          (ex_q),
    .mem_valid   (mem_valid_q),
    .mem_regsel  (mem_regsel_q),
    .hit_ex      (hit1_ex),
    .hit_ex_load (hit1_ex_load),
    .hit_mem     (hit1_mem)
  );

  scoreboard_match u_match2 (
    .en          (id_valid & id_read2en),
    .regsel      (id_read2regsel),
    .ex          (ex_q),
    .mem_valid   (mem_valid_q),
    .mem_regsel  (mem_regsel_q),
    .hit_ex      (hit2_ex),
    .hit_ex_load (hit2_ex_load),
    .hit_mem     (hit2_mem)
  );

  function automatic logic [FWD_W-1:0] fwd_sel(input logic hit_ex, input logic hit_ex_load,
                                               input logic hit_mem);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (hit_ex && !hit_ex_load) sel = FWD_EXMEM;
    else if (hit_mem)           sel = FWD_MEMWB;
    return sel;
  endfunction

  always_comb begin
    stall_cond = 1'b0;
    fwd1_d     = FWD_RF;
    fwd2_d     = FWD_RF;
    if (FORWARD != 32'd0) stall_cond = hit1_ex_load | hit2_ex_load;
    else                  stall_cond = hit1_ex | hit1_mem | hit2_ex | hit2_mem;
    stall = stall_cond & ~flush;
    // Selects only matter for an instruction that actually issues into EX.
    if ((FORWARD != 32'd0) && !stall_cond && !flush) begin
      fwd1_d = fwd_sel(hit1_ex, hit1_ex_load, hit1_mem);
      fwd2_d = fwd_sel(hit2_ex, hit2_ex_load, hit2_mem);
    end
    ex_d.valid   = id_valid & id_write & ~stall & ~flush;
    ex_d.regsel  = id_writeregsel;
    ex_d.is_load = id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_valid_q  <= 1'b0;
      mem_regsel_q <= '0;
      ex_fwd1      <= FWD_RF;
      ex_fwd2      <= FWD_RF;
      stall_count  <= '0;
      err          <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_valid_q  <= ex_q.valid & ~flush;
      mem_regsel_q <= ex_q.regsel;
      ex_fwd1      <= fwd1_d;
      ex_fwd2      <= fwd2_d;
      if (stall && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
      err          <= id_valid & id_is_load & ~id_write;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard with FORWARD=1 and FORWARD=0 instances.
module tb_decode_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_read1en, id_read2en, id_write, id_is_load, flush;
  logic [2:0] id_read1regsel, id_read2regsel, id_writeregsel;

  logic        stall1, err1, stall0, err0;
  logic [1:0]  fwd1_1, fwd2_1, fwd1_0, fwd2_0;
  logic [15:0] cnt1, cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       v;
    logic       w;
    logic [2:0] wr;
    logic       ld;
    logic       r1e;
    logic [2:0] r1;
    logic       r2e;
    logic [2:0] r2;
  } ins_t;

  typedef struct {
    string      tag;
    int         which;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decode_scoreboard #(.FORWARD(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read1en(id_read1en), .id_read2en(id_read2en),
    .id_read1regsel(id_read1regsel), .id_read2regsel(id_read2regsel),
    .id_write(id_write), .id_writeregsel(id_writeregsel), .id_is_load(id_is_load),
    .flush(flush), .stall(stall1), .ex_fwd1(fwd1_1), .ex_fwd2(fwd2_1),
    .stall_count(cnt1), .err(err1)
  );

  decode_scoreboard #(.FORWARD(0)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read1en(id_read1en), .id_read2en(id_read2en),
    .id_read1regsel(id_read1regsel), .id_read2regsel(id_read2regsel),
    .id_write(id_write), .id_writeregsel(id_writeregsel), .id_is_load(id_is_load),
    .flush(flush), .stall(stall0), .ex_fwd1(fwd1_0), .ex_fwd2(fwd2_0),
    .stall_count(cnt0), .err(err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic w, input logic [2:0] wr, input logic ld,
                              input logic r1e, input logic [2:0] r1,
                              input logic r2e, input logic [2:0] r2);
    ins_t i;
    i.v = 1'b1; i.w = w; i.wr = wr; i.ld = ld;
    i.r1e = r1e; i.r1 = r1; i.r2e = r2e; i.r2 = r2;
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic fl);
    id_valid = i.v; id_write = i.w; id_writeregsel = i.wr; id_is_load = i.ld;
    id_read1en = i.r1e; id_read1regsel = i.r1;
    id_read2en = i.r2e; id_read2regsel = i.r2;
    flush = fl;
  endtask

  // One ID cycle: stall is checked mid-cycle, forwarding selects after the edge.
  task automatic step(input ins_t i, input logic fl, input string tag, input int which,
                      input logic es, input logic [1:0] ef1, input logic [1:0] ef2);
    exp_t e;
    drive(i, fl);
    @(negedge clk);
    check_eq({tag, "/stall"}, 32'(which == 0 ? stall0 : stall1), 32'(es));
    sb.push_back('{tag, which, ef1, ef2});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, "/fwd1"}, 32'(e.which == 0 ? fwd1_0 : fwd1_1), 32'(e.f1));
    check_eq({e.tag, "/fwd2"}, 32'(e.which == 0 ? fwd2_0 : fwd2_1), 32'(e.f2));
  endtask

  task automatic idle3(input int which);
    for (int k = 0; k < 3; k++) step('0, 1'b0, "idle", which, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/stall1", 32'(stall1), 32'd0);
    check_eq("rst/stall0", 32'(stall0), 32'd0);
    check_eq("rst/fwd1", 32'({fwd1_1, fwd2_1, fwd1_0, fwd2_0}), 32'd0);
    check_eq("rst/cnt", 32'({cnt1, cnt0}), 32'd0);
    check_eq("rst/err", 32'({err1, err0}), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    drive('0, 1'b0);
    do_reset();

    // FORWARD=1 checks on dut1
    step(mk(1, 3'd3, 0, 0, 3'd0, 0, 3'd0), 0, "alu_p", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd4, 0, 1, 3'd3, 0, 3'd0), 0, "alu_c", 1, 0, 2'b01, 2'b00);
    idle3(1);

    step(mk(1, 3'd5, 1, 0, 3'd0, 0, 3'd0), 0, "ld_p", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd6, 0, 1, 3'd5, 1, 3'd5), 0, "ld_use", 1, 1, 2'b00, 2'b00);
    step(mk(1, 3'd6, 0, 1, 3'd5, 1, 3'd5), 0, "ld_retry", 1, 0, 2'b10, 2'b10);
    check_eq("ld_cnt", 32'(cnt1), 32'd1);
    idle3(1);

    step(mk(1, 3'd2, 0, 0, 3'd0, 0, 3'd0), 0, "d2_p", 1, 0, 2'b00, 2'b00);
    step('0, 0, "d2_nop", 1, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 0, 3'd0, 1, 3'd2), 0, "d2_c", 1, 0, 2'b00, 2'b10);
    idle3(1);

    step(mk(1, 3'd2, 0, 0, 3'd0, 0, 3'd0), 0, "d3_p", 1, 0, 2'b00, 2'b00);
    step('0, 0, "d3_nop", 1, 0, 2'b00, 2'b00);
    step('0, 0, "d3_nop", 1, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 1, 3'd2, 1, 3'd2), 0, "d3_c", 1, 0, 2'b00, 2'b00);
    idle3(1);

    step(mk(1, 3'd1, 0, 0, 3'd0, 0, 3'd0), 0, "two_p1", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd4, 0, 0, 3'd0, 0, 3'd0), 0, "two_p2", 1, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 1, 3'd1, 1, 3'd4), 0, "two_c", 1, 0, 2'b10, 2'b01);
    idle3(1);

    step(mk(1, 3'd3, 0, 0, 3'd0, 0, 3'd0), 0, "young_p1", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd3, 0, 0, 3'd0, 0, 3'd0), 0, "young_p2", 1, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 1, 3'd3, 0, 3'd0), 0, "young_c", 1, 0, 2'b01, 2'b00);
    idle3(1);

    step(mk(1, 3'd0, 0, 0, 3'd0, 0, 3'd0), 0, "r0_p", 1, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 1, 3'd0, 1, 3'd0), 0, "r0_c", 1, 0, 2'b01, 2'b01);
    idle3(1);

    step(mk(1, 3'd5, 1, 0, 3'd0, 0, 3'd0), 0, "fl_p", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd6, 0, 1, 3'd5, 0, 3'd0), 1, "fl_use", 1, 0, 2'b00, 2'b00);
    step(mk(1, 3'd7, 0, 1, 3'd5, 1, 3'd5), 0, "fl_next", 1, 0, 2'b00, 2'b00);
    check_eq("fl_cnt", 32'(cnt1), 32'd1);
    idle3(1);

    // FORWARD=0 checks on dut0
    do_reset();
    step(mk(1, 3'd1, 0, 0, 3'd0, 0, 3'd0), 0, "nf_p", 0, 0, 2'b00, 2'b00);
    step(mk(1, 3'd7, 0, 1, 3'd1, 0, 3'd0), 0, "nf_c1", 0, 1, 2'b00, 2'b00);
    step(mk(1, 3'd7, 0, 1, 3'd1, 0, 3'd0), 0, "nf_c2", 0, 1, 2'b00, 2'b00);
    step(mk(1, 3'd7, 0, 1, 3'd1, 0, 3'd0), 0, "nf_c3", 0, 0, 2'b00, 2'b00);
    check_eq("nf_cnt", 32'(cnt0), 32'd2);
    idle3(0);

    step(mk(1, 3'd2, 0, 0, 3'd0, 0, 3'd0), 0, "nf2_p", 0, 0, 2'b00, 2'b00);
    step('0, 0, "nf2_nop", 0, 0, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 0, 3'd0, 1, 3'd2), 0, "nf2_c1", 0, 1, 2'b00, 2'b00);
    step(mk(0, 3'd0, 0, 0, 3'd0, 1, 3'd2), 0, "nf2_c2", 0, 0, 2'b00, 2'b00);
    check_eq("nf2_cnt", 32'(cnt0), 32'd3);

    // Self-dependent producer stalls two of every three cycles; long enough to saturate.
    drive(mk(1, 3'd1, 0, 1, 3'd1, 0, 3'd0), 1'b0);
    repeat (98400) @(posedge clk);
    #1;
    check_eq("sat_cnt", 32'(cnt0), 32'h0000FFFF);

    step(mk(0, 3'd0, 1, 0, 3'd0, 0, 3'd0), 0, "err_in", 1, 0, 2'b00, 2'b00);
    check_eq("err_set1", 32'(err1), 32'd1);
    check_eq("err_set0", 32'(err0), 32'd1);
    step('0, 0, "err_clr", 1, 0, 2'b00, 2'b00);
    check_eq("err_clr1", 32'(err1), 32'd0);

    step(mk(1, 3'd1, 0, 0, 3'd0, 0, 3'd0), 0, "rs_p", 0, 0, 2'b00, 2'b00);
    drive(mk(1, 3'd6, 0, 1, 3'd1, 0, 3'd0), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rs_mid_stall", 32'(stall0), 32'd1);
    @(posedge clk);
    #1;
    check_eq("rs_stall", 32'({stall1, stall0}), 32'd0);
    check_eq("rs_fwd", 32'({fwd1_1, fwd2_1, fwd1_0, fwd2_0}), 32'd0);
    check_eq("rs_cnt", 32'({cnt1, cnt0}), 32'd0);
    check_eq("rs_err", 32'({err1, err0}), 32'd0);
    rst = 1'b0;
    drive('0, 1'b0);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Decode-stage hazard unit for the 16-bit, 8-register pipeline. It tracks the destination registers of the instructions in flight in EX, MEM and WB, and from these it does three things. It stalls ID when a source operand cannot yet be supplied. It produces registered operand-forwarding selects that the EX stage consumes. It keeps a stall-cycle performance counter. It sits beside the bypassing register file in ID: the WB-to-ID same-cycle case is already resolved by the register file, so this block ignores it.

## Interface
Parameters:
- FORWARD, default 1. 1 means EX/MEM and MEM/WB forwarding paths exist. 0 means no forwarding, so the block stalls until the producer reaches WB.

Ports:
- Reset is synchronous and active-high. One clock domain.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_read1en / id_read2en  in  1 each  source operand 1/2 is used
- id_read1regsel / id_read2regsel  in  3 each  source register numbers
- id_write  in  1  instruction writes a register
- id_writeregsel  in  3  destination register
- id_is_load  in  1  destination value comes from memory (available end of MEM)
- flush  in  1  squash the instruction in ID and the entry in EX (branch taken in EX)
- stall  out  1  hold PC and the IF/ID latch, insert a bubble into EX; combinational
- ex_fwd1 / ex_fwd2  out  2 each  registered operand select for the EX stage: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven
- stall_count  out  16  saturating count of stalled cycles
- err  out  1  registered; set for one cycle when ID presents id_valid & id_is_load & !id_write

## Operation
- Three in-flight entries: EX, MEM, WB. Each entry holds {valid, regsel[2:0], is_load}. An entry is valid only for instructions that write a register.
- A source matches an entry when all of these hold: id_valid, the corresponding readNen, entry.valid, and regsel equal to the entry's register.
- Stall condition, FORWARD=1: a source matches EX and EX.is_load (load-use).
- Stall condition, FORWARD=0: a source matches EX or MEM.
- stall = stall condition & !flush. Flush always wins.
- Entry advance happens every cycle:
  - WB is retired.
  - MEM moves to WB.
  - EX moves to MEM.
  - EX is loaded with {id_valid & id_write & !stall & !flush, id_writeregsel, id_is_load}.
  - On flush, the EX→MEM move writes an invalid MEM entry.
- Forward select for each source (FORWARD=1, not stalling, not flushing), youngest first:
  - match EX (not load) → 01
  - else match MEM → 10
  - else → 00
- When FORWARD=0, stalling, or flushing, the next ex_fwdN is 00.
- stall_count increments on every cycle with stall=1 and saturates at 16'hFFFF.
- Reset clears:
  - all entries invalid
  - ex_fwd1 = ex_fwd2 = 00
  - stall_count = 0
  - err = 0
  - stall = 0, since no entries are valid

## Timing
- stall is valid in the same cycle as the ID inputs. There is no registered delay.
- ex_fwdN is latched at the ID→EX clock edge and is valid for the whole cycle in which the instruction is in EX.
- Load-use with FORWARD=1:
  - 1 stall cycle.
  - On the retry the load sits in MEM, so the next ex_fwd = 10.
- FORWARD=0:
  - 2 stall cycles after an adjacent producer.
  - 1 stall cycle when the producer is two instructions ahead.
- Both sources may match different entries; each select is resolved independently.
- A source of r0 is treated like any other register. There is no hardwired zero.
- Reset asserted mid-stall clears all entries at the next edge, and stall drops in the following cycle.

## Structure
- The shared pipeline package holds:
  - the FWD_RF / FWD_EXMEM / FWD_MEMWB 2-bit encodings
  - the in-flight entry record type
  - the register-select width (3)
- Natural sub-module: scoreboard_match. It is combinational and takes one source {en, regsel} plus the three entries, returning {hit_ex, hit_ex_load, hit_mem}. It is instantiated twice.

## Test plan
- ALU-ALU: I1 writes r3, I2 reads r3 on operand 1 (FORWARD=1) → stall=0, ex_fwd1=01 during I2's EX.
- Load-use: load to r5, next instruction reads r5 on both operands → stall=1 for exactly 1 cycle, stall_count=1; on the retry ex_fwd1=ex_fwd2=10.
- Distance 2: I1 writes r2, a NOP, I3 reads r2 → ex_fwd=10. At distance 3 → 00 and no stall.
- FORWARD=0: adjacent write of r1 then read of r1 → 2 stall cycles, ex_fwd always 00.
- Flush during load-use stall: flush=1 → stall=0 that cycle, EX entry invalid next cycle, and the younger read does not stall afterwards.
- Counter and error:
  - Hold a stall for 70000 cycles (FORWARD=0, force entries via repeated producers) → stall_count=FFFF.
  - Present id_is_load=1, id_write=0 → err=1 for one cycle.
  - Then assert rst → all outputs 0.
